// File: rtl/game_flow_if.sv
// ---------------------------------------------------------------------------
// game_flow_if
// Bundles the match sequencer's player-facing inputs and screen/score outputs.
//   enter, p1_point, p2_point, yes, no : driven by the button/ball logic
//   score1, score2, won                : match result towards the display
//   screen_sel, cont_reset, ball_hold, busy : screen and ball control
// The master modport is the surrounding system; the slave modport is the
// sequencer itself.
// ---------------------------------------------------------------------------
interface game_flow_if #(
    parameter int SCORE_W = 4
);
    logic               enter;
    logic               p1_point;
    logic               p2_point;
    logic               yes;
    logic               no;
    logic [SCORE_W-1:0] score1;
    logic [SCORE_W-1:0] score2;
    logic               won;
    logic [1:0]         screen_sel;
    logic               cont_reset;
    logic               ball_hold;
    logic               busy;

    modport master (
        output enter, p1_point, p2_point, yes, no,
        input  score1, score2, won, screen_sel, cont_reset, ball_hold, busy
    );

    modport slave (
        input  enter, p1_point, p2_point, yes, no,
        output score1, score2, won, screen_sel, cont_reset, ball_hold, busy
    );
endinterface

// File: rtl/game_flow_ctrl.sv
// ---------------------------------------------------------------------------
// game_flow_ctrl
// Match sequencer: title screen -> serve delay -> play -> continue screen.
// Counts points, declares the winner, picks the displayed screen and handles
// the yes/no decision on the continue screen.
//   clk, reset : system clock, synchronous active-high reset
//   bus        : game_flow_if slave (buttons/points in, scores/screen out)
// All outputs are registered; output registers are loaded from the next
// state so they line up with the state register.
// ---------------------------------------------------------------------------
module game_flow_ctrl #(
    parameter int WIN_SCORE    = 5,
    parameter int SCORE_W      = 4,
    parameter int SERVE_CYCLES = 50000000
) (
    input  logic        clk,
    input  logic        reset,
    game_flow_if.slave  bus
);
    localparam int                 CNT_W    = (SERVE_CYCLES > 1) ? $clog2(SERVE_CYCLES) : 1;
    localparam logic [CNT_W-1:0]   CNT_LOAD = CNT_W'(SERVE_CYCLES - 1);
    localparam logic [SCORE_W-1:0] WIN      = SCORE_W'(WIN_SCORE);

    typedef enum logic [1:0] {
        TITLE     = 2'd0,
        SERVE     = 2'd1,
        PLAY      = 2'd2,
        GAME_OVER = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [SCORE_W-1:0] score1_q, score1_d;
    logic [SCORE_W-1:0] score2_q, score2_d;
    logic               won_q, won_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               armed_q, armed_d;
    logic               enter_q, enter_d;
    logic [1:0]         screen_sel_q, screen_sel_d;
    logic               cont_reset_q, cont_reset_d;
    logic               ball_hold_q, ball_hold_d;
    logic               busy_q, busy_d;
    logic               enter_rise;

    // Saturating increment: a score can never wrap past its maximum.
    function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] v);
        return (v == {SCORE_W{1'b1}}) ? v : v + SCORE_W'(1);
    endfunction

    always_comb begin
        state_d    = state_q;
        score1_d   = score1_q;
        score2_d   = score2_q;
        won_d      = won_q;
        cnt_d      = cnt_q;
        armed_d    = armed_q;
        enter_d    = bus.enter;
        enter_rise = bus.enter & ~enter_q;

        case (state_q)
            TITLE: begin
                if (enter_rise) begin
                    score1_d = '0;
                    score2_d = '0;
                    won_d    = 1'b0;
                    cnt_d    = CNT_LOAD;
                    state_d  = SERVE;
                end
            end
            SERVE: begin
                // Point pulses are deliberately ignored while the ball is held.
                if (cnt_q == '0) state_d = PLAY;
                else             cnt_d   = cnt_q - CNT_W'(1);
            end
            PLAY: begin
                if (bus.p1_point && bus.p2_point) begin
                    // Simultaneous points cancel: replay the point.
                    cnt_d   = CNT_LOAD;
                    state_d = SERVE;
                end else if (bus.p1_point) begin
                    score1_d = sat_inc(score1_q);
                    if (sat_inc(score1_q) == WIN) begin
                        won_d   = 1'b0;
                        armed_d = 1'b0;
                        state_d = GAME_OVER;
                    end else begin
                        cnt_d   = CNT_LOAD;
                        state_d = SERVE;
                    end
                end else if (bus.p2_point) begin
                    score2_d = sat_inc(score2_q);
                    if (sat_inc(score2_q) == WIN) begin
                        won_d   = 1'b1;
                        armed_d = 1'b0;
                        state_d = GAME_OVER;
                    end else begin
                        cnt_d   = CNT_LOAD;
                        state_d = SERVE;
                    end
                end
            end
            GAME_OVER: begin
                // The press that ended the match (or a held enter) must be
                // released before yes/no are honoured.
                if (!armed_q) begin
                    if (!bus.enter) armed_d = 1'b1;
                end else if (bus.yes) begin
                    score1_d = '0;
                    score2_d = '0;
                    cnt_d    = CNT_LOAD;
                    state_d  = SERVE;
                end else if (bus.no) begin
                    state_d = TITLE;
                end
            end
            default: state_d = TITLE;
        endcase

        screen_sel_d = (state_d == TITLE)     ? 2'b00 :
                       (state_d == GAME_OVER) ? 2'b10 : 2'b01;
        ball_hold_d  = (state_d != PLAY);
        busy_d       = (state_d == SERVE) || (state_d == PLAY);
        // One-cycle pulse on entry so the arrow selector starts on YES.
        cont_reset_d = (state_d == GAME_OVER) && (state_q != GAME_OVER);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= TITLE;
            score1_q     <= '0;
            score2_q     <= '0;
            won_q        <= 1'b0;
            cnt_q        <= '0;
            armed_q      <= 1'b0;
            enter_q      <= 1'b0;
            screen_sel_q <= 2'b00;
            cont_reset_q <= 1'b1;
            ball_hold_q  <= 1'b1;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            score1_q     <= score1_d;
            score2_q     <= score2_d;
            won_q        <= won_d;
            cnt_q        <= cnt_d;
            armed_q      <= armed_d;
            enter_q      <= enter_d;
            screen_sel_q <= screen_sel_d;
            cont_reset_q <= cont_reset_d;
            ball_hold_q  <= ball_hold_d;
            busy_q       <= busy_d;
        end
    end

    assign bus.score1     = score1_q;
    assign bus.score2     = score2_q;
    assign bus.won        = won_q;
    assign bus.screen_sel = screen_sel_q;
    assign bus.cont_reset = cont_reset_q;
    assign bus.ball_hold  = ball_hold_q;
    assign bus.busy       = busy_q;
endmodule

// File: tb/tb_game_flow_ctrl.sv
// ---------------------------------------------------------------------------
// tb_game_flow_ctrl
// Directed bench for game_flow_ctrl (WIN_SCORE=3, SERVE_CYCLES=4). The
// stimulus process pushes the hand-computed output snapshot expected after
// each clock edge into a queue; a separate monitor pops and compares on the
// falling edge.
// ---------------------------------------------------------------------------
module tb_game_flow_ctrl;
    localparam int WIN_SCORE    = 3;
    localparam int SCORE_W      = 4;
    localparam int SERVE_CYCLES = 4;

    typedef struct {
        string      name;
        int         cyc;
        logic [1:0] ss;
        logic       bh;
        logic       bs;
        logic       cr;
        logic       w;
        logic [3:0] s1;
        logic [3:0] s2;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;
    exp_t sb[$];

    game_flow_if #(.SCORE_W(SCORE_W)) bus ();

    game_flow_ctrl #(
        .WIN_SCORE   (WIN_SCORE),
        .SCORE_W     (SCORE_W),
        .SERVE_CYCLES(SERVE_CYCLES)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc = cyc + 1;
    end

    // Monitor: outputs are compared every cycle that has a queued expectation.
    initial forever begin
        @(negedge clk);
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            exp_t e;
            e = sb.pop_front();
            checks = checks + 1;
            if (e.cyc != cyc ||
                bus.screen_sel !== e.ss || bus.ball_hold !== e.bh ||
                bus.busy !== e.bs || bus.cont_reset !== e.cr ||
                bus.won !== e.w || bus.score1 !== e.s1 || bus.score2 !== e.s2) begin
                errors = errors + 1;
                $display("FAIL %s cyc=%0d: got ss=%b hold=%b busy=%b cr=%b won=%b s1=%0d s2=%0d, want ss=%b hold=%b busy=%b cr=%b won=%b s1=%0d s2=%0d (due cyc %0d)",
                         e.name, cyc, bus.screen_sel, bus.ball_hold, bus.busy, bus.cont_reset,
                         bus.won, bus.score1, bus.score2, e.ss, e.bh, e.bs, e.cr, e.w,
                         e.s1, e.s2, e.cyc);
            end
        end
    end

    // One cycle: apply inputs, queue the outputs expected after the next edge.
    task automatic t(input string nm, input logic r, e, p1, p2, y, n,
                     input logic [1:0] ss, input logic bh, bs, cr, w,
                     input logic [3:0] s1, s2);
        exp_t x;
        reset        = r;
        bus.enter    = e;
        bus.p1_point = p1;
        bus.p2_point = p2;
        bus.yes      = y;
        bus.no       = n;
        x.name = nm; x.cyc = cyc + 1; x.ss = ss; x.bh = bh; x.bs = bs;
        x.cr = cr; x.w = w; x.s1 = s1; x.s2 = s2;
        sb.push_back(x);
        @(posedge clk);
        #1;
    endtask

    // Remaining three serve cycles (point pulses must be ignored), then PLAY.
    task automatic serve_rest(input string nm, input logic w, input logic [3:0] s1, s2);
        t(nm, 0, 0, 1, 0, 0, 0, 2'b01, 1, 1, 0, w, s1, s2);
        t(nm, 0, 0, 0, 1, 0, 0, 2'b01, 1, 1, 0, w, s1, s2);
        t(nm, 0, 0, 1, 1, 0, 0, 2'b01, 1, 1, 0, w, s1, s2);
        t({nm, "_play"}, 0, 0, 0, 0, 0, 0, 2'b01, 0, 1, 0, w, s1, s2);
    endtask

    initial begin
        #(100000 * 10);
        $display("FAIL timeout: simulation did not finish, got running want finished");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1;
        bus.enter = 0; bus.p1_point = 0; bus.p2_point = 0; bus.yes = 0; bus.no = 0;

        //     name        r e p1 p2 y n   ss   bh bs cr w s1 s2
        t("reset",        1,0,0,0,0,0, 2'b00, 1,0,1,0, 0,0);
        t("title",        0,0,0,0,0,0, 2'b00, 1,0,0,0, 0,0);
        t("start",        0,1,0,0,0,0, 2'b01, 1,1,0,0, 0,0);
        serve_rest("srv0", 0, 0, 0);
        t("idle_play",    0,0,0,0,0,0, 2'b01, 0,1,0,0, 0,0);
        t("p2_a",         0,0,0,1,0,0, 2'b01, 1,1,0,0, 0,1);
        serve_rest("srv1", 0, 0, 1);
        t("p2_b",         0,0,0,1,0,0, 2'b01, 1,1,0,0, 0,2);
        serve_rest("srv2", 0, 0, 2);
        t("win_p2",       0,1,0,1,0,0, 2'b10, 1,0,1,1, 0,3);
        t("held_yes1",    0,1,0,0,1,0, 2'b10, 1,0,0,1, 0,3);
        t("held_yes2",    0,1,0,0,1,0, 2'b10, 1,0,0,1, 0,3);
        t("release",      0,0,0,0,0,0, 2'b10, 1,0,0,1, 0,3);
        t("yes_and_no",   0,1,0,0,1,1, 2'b01, 1,1,0,1, 0,0);
        serve_rest("srv3", 1, 0, 0);
        t("p2_c",         0,0,0,1,0,0, 2'b01, 1,1,0,1, 0,1);
        serve_rest("srv4", 1, 0, 1);
        t("p2_d",         0,0,0,1,0,0, 2'b01, 1,1,0,1, 0,2);
        serve_rest("srv5", 1, 0, 2);
        t("win_p2_2",     0,0,0,1,0,0, 2'b10, 1,0,1,1, 0,3);
        t("arm",          0,0,0,0,0,0, 2'b10, 1,0,0,1, 0,3);
        t("no",           0,1,0,0,0,1, 2'b00, 1,0,0,1, 0,3);
        t("title_hold",   0,0,0,0,0,0, 2'b00, 1,0,0,1, 0,3);
        t("start2",       0,1,0,0,0,0, 2'b01, 1,1,0,0, 0,0);
        serve_rest("srv6", 0, 0, 0);
        t("p1_a",         0,0,1,0,0,0, 2'b01, 1,1,0,0, 1,0);
        serve_rest("srv7", 0, 1, 0);
        t("p2_e",         0,0,0,1,0,0, 2'b01, 1,1,0,0, 1,1);
        serve_rest("srv8", 0, 1, 1);
        t("p1_b",         0,0,1,0,0,0, 2'b01, 1,1,0,0, 2,1);
        serve_rest("srv9", 0, 2, 1);
        t("p2_f",         0,0,0,1,0,0, 2'b01, 1,1,0,0, 2,2);
        serve_rest("srv10", 0, 2, 2);
        t("both_points",  0,0,1,1,0,0, 2'b01, 1,1,0,0, 2,2);
        serve_rest("srv_replay", 0, 2, 2);
        t("win_p1",       0,0,1,0,0,0, 2'b10, 1,0,1,0, 3,2);
        t("arm2",         0,0,0,0,0,0, 2'b10, 1,0,0,0, 3,2);
        t("rst_go",       1,0,0,0,0,0, 2'b00, 1,0,1,0, 0,0);
        t("title2",       0,0,0,0,0,0, 2'b00, 1,0,0,0, 0,0);
        t("start3",       0,1,0,0,0,0, 2'b01, 1,1,0,0, 0,0);
        t("srv_part",     0,0,0,0,0,0, 2'b01, 1,1,0,0, 0,0);
        t("rst_srv",      1,0,0,0,0,0, 2'b00, 1,0,1,0, 0,0);
        t("title3",       0,0,0,0,0,0, 2'b00, 1,0,0,0, 0,0);
        t("start4",       0,1,0,0,0,0, 2'b01, 1,1,0,0, 0,0);
        serve_rest("srv_full", 0, 0, 0);

        repeat (3) @(negedge clk);
        if (sb.size() != 0) begin
            errors = errors + sb.size();
            $display("FAIL drain: %0d expectations left unchecked, want 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
